// File: rtl/falling_edge_sched_pkg.sv
// Shared types and default sizing for the falling-edge scheduler.
// The channel FSM encoding lives here so the top and any bench can agree on it.
package falling_edge_sched_pkg;

    typedef enum logic [1:0] {
        CH_IDLE = 2'd0,
        CH_WAIT = 2'd1,
        CH_PEND = 2'd2
    } ch_state_e;

    localparam int DEF_N_CH  = 4;
    localparam int DEF_DLY_W = 4;

    // A falling edge is a registered 1 followed by a live 0.
    function automatic logic fell(input logic prev, input logic cur);
        return prev & ~cur;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: picks the first requester at or after ptr, wrapping modulo N.
// The pointer moves past the winner only when the caller consumes the grant.
module rr_arbiter #(
    parameter int N = 4,
    parameter int W = (N > 1) ? $clog2(N) : 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    input  logic         advance,
    output logic         gnt_valid,
    output logic [W-1:0] gnt_idx
);

    logic [W-1:0] ptr;

    // Scan from the farthest offset down so the nearest requester wins last.
    always_comb begin
        int j;
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        j         = 0;
        for (int i = N - 1; i >= 0; i--) begin
            j = int'(ptr) + i;
            if (j >= N) begin
                j = j - N;
            end
            if (req[W'(j)]) begin
                gnt_valid = 1'b1;
                gnt_idx   = W'(j);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else if (advance && gnt_valid) begin
            ptr <= (gnt_idx == W'(N - 1)) ? '0 : gnt_idx + W'(1);
        end
    end

endmodule

// File: rtl/falling_edge_scheduler.sv
// Multi-channel falling-edge delay scheduler: each channel delays its edge by a
// programmable count, then matured events share one valid/ready port via round-robin.
module falling_edge_scheduler
    import falling_edge_sched_pkg::*;
#(
    parameter int N_CH  = DEF_N_CH,
    parameter int DLY_W = DEF_DLY_W,
    parameter int CH_W  = $clog2(N_CH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_CH-1:0]  x_i,
    input  logic [DLY_W-1:0] cfg_delay_i,
    output logic             evt_valid_o,
    output logic [CH_W-1:0]  evt_ch_o,
    input  logic             evt_ready_i,
    output logic [N_CH-1:0]  busy_o,
    output logic [N_CH-1:0]  overrun_o,
    input  logic             ovr_clr_i
);

    logic [N_CH-1:0] x_q;
    logic [N_CH-1:0] fall;
    logic [N_CH-1:0] pend;
    logic [N_CH-1:0] grant;
    logic [N_CH-1:0] ovr_set;
    logic            load;
    logic            gnt_valid;
    logic [CH_W-1:0] gnt_idx;

    // ---- Stage 0: edge detection (x_q resets low so a held-low input never fires)
    always_ff @(posedge clk) begin
        if (rst) begin
            x_q <= '0;
        end else begin
            x_q <= x_i;
        end
    end

    // The output register refills whenever it is empty or being drained this cycle.
    assign load = ~evt_valid_o | evt_ready_i;

    rr_arbiter #(
        .N (N_CH),
        .W (CH_W)
    ) u_arb (
        .clk       (clk),
        .rst       (rst),
        .req       (pend),
        .advance   (load),
        .gnt_valid (gnt_valid),
        .gnt_idx   (gnt_idx)
    );

    // ---- Stage 1: per-channel delay FSM
    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        ch_state_e        state;
        ch_state_e        state_nxt;
        logic [DLY_W-1:0] cnt;
        logic [DLY_W-1:0] cnt_nxt;

        assign fall[c]    = fell(x_q[c], x_i[c]);
        assign pend[c]    = (state == CH_PEND);
        assign busy_o[c]  = (state != CH_IDLE);
        assign grant[c]   = load & gnt_valid & (gnt_idx == CH_W'(c));
        // Any non-idle state drops the edge, including the cycle the grant retires PEND.
        assign ovr_set[c] = fall[c] & (state != CH_IDLE);

        always_comb begin
            state_nxt = state;
            cnt_nxt   = cnt;
            case (state)
                CH_IDLE: begin
                    if (fall[c]) begin
                        cnt_nxt   = cfg_delay_i;
                        state_nxt = (cfg_delay_i == '0) ? CH_PEND : CH_WAIT;
                    end
                end
                CH_WAIT: begin
                    cnt_nxt = cnt - DLY_W'(1);
                    if (cnt == DLY_W'(1)) begin
                        state_nxt = CH_PEND;
                    end
                end
                CH_PEND: begin
                    if (grant[c]) begin
                        state_nxt = CH_IDLE;
                    end
                end
                default: state_nxt = CH_IDLE;
            endcase
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                state <= CH_IDLE;
                cnt   <= '0;
            end else begin
                state <= state_nxt;
                cnt   <= cnt_nxt;
            end
        end
    end

    // ---- Stage 2: shared output register and sticky overrun flags
    always_ff @(posedge clk) begin
        if (rst) begin
            evt_valid_o <= 1'b0;
            evt_ch_o    <= '0;
        end else if (load) begin
            evt_valid_o <= gnt_valid;
            if (gnt_valid) begin
                evt_ch_o <= gnt_idx;
            end
        end
    end

    // A new overrun outranks a simultaneous clear on the same bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            overrun_o <= '0;
        end else begin
            overrun_o <= (overrun_o & ~{N_CH{ovr_clr_i}}) | ovr_set;
        end
    end

endmodule

// File: tb/tb_falling_edge_scheduler.sv
// Scoreboarded bench for falling_edge_scheduler: expected events are queued when
// edges are driven and checked against every output transfer.
module tb_falling_edge_scheduler;

    localparam int N_CH  = 4;
    localparam int DLY_W = 4;
    localparam int CH_W  = 2;

    typedef struct {
        int ch;
        int cyc;
    } exp_t;

    logic             clk;
    logic             rst;
    logic [N_CH-1:0]  x_i;
    logic [DLY_W-1:0] cfg_delay_i;
    logic             evt_valid_o;
    logic [CH_W-1:0]  evt_ch_o;
    logic             evt_ready_i;
    logic [N_CH-1:0]  busy_o;
    logic [N_CH-1:0]  overrun_o;
    logic             ovr_clr_i;

    exp_t sb[$];
    exp_t mon_e;
    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;

    falling_edge_scheduler #(
        .N_CH  (N_CH),
        .DLY_W (DLY_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .x_i         (x_i),
        .cfg_delay_i (cfg_delay_i),
        .evt_valid_o (evt_valid_o),
        .evt_ch_o    (evt_ch_o),
        .evt_ready_i (evt_ready_i),
        .busy_o      (busy_o),
        .overrun_o   (overrun_o),
        .ovr_clr_i   (ovr_clr_i)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Transfers are observed at the posedge that completes them; cyc numbers posedges.
    always @(posedge clk) begin
        if (!rst && evt_valid_o === 1'b1 && evt_ready_i === 1'b1) begin
            vectors++;
            if (sb.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_event: got ch=%0d at cycle %0d, required no event", evt_ch_o, cyc);
            end else begin
                mon_e = sb.pop_front();
                if (int'(evt_ch_o) != mon_e.ch || (mon_e.cyc >= 0 && cyc != mon_e.cyc)) begin
                    miscompares++;
                    $display("FAIL event: got ch=%0d cycle=%0d, required ch=%0d cycle=%0d",
                             evt_ch_o, cyc, mon_e.ch, mon_e.cyc);
                end
            end
        end
        cyc = cyc + 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while (sb.size() != 0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL %s_drain: got %0d events outstanding, required 0", name, sb.size());
            sb.delete();
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset();
        vectors += 4;
        if (evt_valid_o !== 1'b0) begin
            miscompares++; $display("FAIL reset_valid: got %b, required 0", evt_valid_o);
        end
        if (evt_ch_o !== 2'd0) begin
            miscompares++; $display("FAIL reset_ch: got %0d, required 0", evt_ch_o);
        end
        if (busy_o !== 4'b0000) begin
            miscompares++; $display("FAIL reset_busy: got %b, required 0000", busy_o);
        end
        if (overrun_o !== 4'b0000) begin
            miscompares++; $display("FAIL reset_overrun: got %b, required 0000", overrun_o);
        end
    endtask

    task automatic test_single();
        int k;
        cfg_delay_i = 4'd2;
        x_i = 4'b0001;
        repeat (4) @(negedge clk);
        k = cyc;
        x_i[0] = 1'b0;
        sb.push_back(exp_t'{ch: 0, cyc: k + 4});
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            // Later delay changes must not touch the in-flight channel.
            if (i == 0) cfg_delay_i = 4'd9;
            vectors += 2;
            if (busy_o[0] !== (i < 3)) begin
                miscompares++; $display("FAIL single_busy[%0d]: got %b, required %b", i, busy_o[0], (i < 3));
            end
            if (evt_valid_o !== (i == 3)) begin
                miscompares++; $display("FAIL single_valid[%0d]: got %b, required %b", i, evt_valid_o, (i == 3));
            end
            if (i == 3) begin
                vectors++;
                if (evt_ch_o !== 2'd0) begin
                    miscompares++; $display("FAIL single_ch: got %0d, required 0", evt_ch_o);
                end
            end
        end
        wait_drain("single");
    endtask

    task automatic test_d0();
        int k;
        x_i = 4'b0100;
        repeat (2) @(negedge clk);
        cfg_delay_i = 4'd0;
        k = cyc;
        x_i[2] = 1'b0;
        sb.push_back(exp_t'{ch: 2, cyc: k + 2});
        @(negedge clk);
        vectors += 2;
        if (evt_valid_o !== 1'b0) begin
            miscompares++; $display("FAIL d0_early_valid: got %b, required 0", evt_valid_o);
        end
        if (busy_o !== 4'b0100) begin
            miscompares++; $display("FAIL d0_busy: got %b, required 0100", busy_o);
        end
        @(negedge clk);
        vectors += 3;
        if (evt_valid_o !== 1'b1) begin
            miscompares++; $display("FAIL d0_valid: got %b, required 1", evt_valid_o);
        end
        if (evt_ch_o !== 2'd2) begin
            miscompares++; $display("FAIL d0_ch: got %0d, required 2", evt_ch_o);
        end
        if (overrun_o !== 4'b0000) begin
            miscompares++; $display("FAIL d0_overrun: got %b, required 0000", overrun_o);
        end
        wait_drain("d0");
    endtask

    task automatic test_simultaneous();
        int k;
        do_reset();
        x_i = 4'b1011;
        repeat (2) @(negedge clk);
        cfg_delay_i = 4'd1;
        k = cyc;
        x_i = 4'b0000;
        sb.push_back(exp_t'{ch: 0, cyc: k + 3});
        sb.push_back(exp_t'{ch: 1, cyc: k + 4});
        sb.push_back(exp_t'{ch: 3, cyc: k + 5});
        wait_drain("simul_a");
        // Pointer wrapped to 0 after granting ch3, so ch0 leads again.
        x_i = 4'b0011;
        repeat (2) @(negedge clk);
        k = cyc;
        x_i = 4'b0000;
        sb.push_back(exp_t'{ch: 0, cyc: k + 3});
        sb.push_back(exp_t'{ch: 1, cyc: k + 4});
        wait_drain("simul_b");
        vectors++;
        if (overrun_o !== 4'b0000) begin
            miscompares++; $display("FAIL simul_overrun: got %b, required 0000", overrun_o);
        end
    endtask

    task automatic test_backpressure();
        int k;
        do_reset();
        evt_ready_i = 1'b0;
        x_i = 4'b0110;
        repeat (2) @(negedge clk);
        cfg_delay_i = 4'd1;
        k = cyc;
        x_i = 4'b0000;
        sb.push_back(exp_t'{ch: 1, cyc: k + 7});
        sb.push_back(exp_t'{ch: 2, cyc: k + 8});
        repeat (2) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            vectors += 3;
            if (evt_valid_o !== 1'b1) begin
                miscompares++; $display("FAIL bp_valid[%0d]: got %b, required 1", i, evt_valid_o);
            end
            if (evt_ch_o !== 2'd1) begin
                miscompares++; $display("FAIL bp_ch[%0d]: got %0d, required 1", i, evt_ch_o);
            end
            if (busy_o !== 4'b0100) begin
                miscompares++; $display("FAIL bp_busy[%0d]: got %b, required 0100", i, busy_o);
            end
        end
        evt_ready_i = 1'b1;
        wait_drain("backpressure");
    endtask

    task automatic test_overrun();
        int k;
        do_reset();
        x_i = 4'b0011;
        repeat (2) @(negedge clk);
        cfg_delay_i = 4'd8;
        k = cyc;
        x_i[0] = 1'b0;
        sb.push_back(exp_t'{ch: 0, cyc: k + 10});
        sb.push_back(exp_t'{ch: 1, cyc: k + 12});
        @(negedge clk);
        x_i[0] = 1'b1;
        @(negedge clk);
        x_i[1] = 1'b0;
        @(negedge clk);
        x_i[0] = 1'b0;
        @(negedge clk);
        vectors += 2;
        if (overrun_o !== 4'b0001) begin
            miscompares++; $display("FAIL ovr_set: got %b, required 0001", overrun_o);
        end
        if (busy_o !== 4'b0011) begin
            miscompares++; $display("FAIL ovr_busy: got %b, required 0011", busy_o);
        end
        x_i[1] = 1'b1;
        @(negedge clk);
        // Second ch1 edge lands in the same cycle as the clear.
        x_i[1] = 1'b0;
        ovr_clr_i = 1'b1;
        @(negedge clk);
        ovr_clr_i = 1'b0;
        vectors++;
        if (overrun_o !== 4'b0010) begin
            miscompares++; $display("FAIL ovr_set_wins: got %b, required 0010", overrun_o);
        end
        wait_drain("overrun");
        vectors++;
        if (overrun_o !== 4'b0010) begin
            miscompares++; $display("FAIL ovr_sticky: got %b, required 0010", overrun_o);
        end
        ovr_clr_i = 1'b1;
        @(negedge clk);
        ovr_clr_i = 1'b0;
        vectors++;
        if (overrun_o !== 4'b0000) begin
            miscompares++; $display("FAIL ovr_clear: got %b, required 0000", overrun_o);
        end
    endtask

    task automatic test_reset_mid();
        int k;
        do_reset();
        x_i = 4'b0001;
        repeat (2) @(negedge clk);
        cfg_delay_i = 4'd6;
        k = cyc;
        x_i = 4'b0000;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        vectors += 2;
        if (busy_o !== 4'b0000) begin
            miscompares++; $display("FAIL rstmid_busy: got %b, required 0000 (edge at %0d)", busy_o, k);
        end
        if (evt_valid_o !== 1'b0) begin
            miscompares++; $display("FAIL rstmid_valid: got %b, required 0", evt_valid_o);
        end
        repeat (20) @(negedge clk);
        vectors += 2;
        if (busy_o !== 4'b0000) begin
            miscompares++; $display("FAIL rstmid_busy_late: got %b, required 0000", busy_o);
        end
        if (overrun_o !== 4'b0000) begin
            miscompares++; $display("FAIL rstmid_overrun: got %b, required 0000", overrun_o);
        end
        wait_drain("reset_mid");
    endtask

    initial begin
        rst         = 1'b1;
        x_i         = '0;
        cfg_delay_i = '0;
        evt_ready_i = 1'b1;
        ovr_clr_i   = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        test_reset();
        test_single();
        test_d0();
        test_simultaneous();
        test_backpressure();
        test_overrun();
        test_reset_mid();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
